prod_accum_stage: RTL
=====================

Name: prod_accum_stage

Overview:
Downstream consumer of the team's 32-bit signed 16x16 product stream. It accumulates VEC_LEN consecutive products, or fewer if flushed early, into a wide signed sum, forming a dot-product/MAC back end. A one-entry output buffer with valid/ready lets the next vector accumulate while the previous sum waits for the consumer.

Parameters:
- PROD_W, 32, width of the signed input product.
- VEC_LEN, 8, number of products per vector (1..256).
- ACC_W, 40, accumulator and sum width. Must satisfy ACC_W >= PROD_W + clog2(VEC_LEN); elaboration-time assertion.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_prod_valid  in  1  product valid.
- o_prod_ready  out  1  stage can accept a product this cycle.
- i_prod  in  PROD_W  signed product.
- i_flush  in  1  close current vector early.
- o_sum_valid  out  1  sum buffer holds a result.
- i_sum_ready  in  1  consumer takes the sum.
- o_sum  out  ACC_W  signed accumulated sum.
- o_sum_cnt  out  9  number of products in o_sum (1..VEC_LEN).
- o_sat  out  1  sum was clipped (MAC_SAT_EN only; tied 0 otherwise).

Behaviour:
- One clock domain; reset is synchronous and active-low.
- Reset values: acc=0, cnt=0, buffer BUF_EMPTY, o_sum_valid=0, o_sum=0, o_sum_cnt=0, o_sat=0.
- A reset mid-vector discards the partial accumulation and any buffered sum.
- Accept condition: accept = i_prod_valid && o_prod_ready.
- On accept: acc <= acc + sext(i_prod) and cnt <= cnt+1, unless the vector closes this cycle.
- Vector close event: an accept with cnt==VEC_LEN-1, OR i_flush with (cnt>0 OR accept).
- On close:
  - The buffer loads acc + (accept ? sext(i_prod) : 0) and the matching count.
  - acc <= 0 and cnt <= 0.
  - o_sum_valid=1 from the next cycle. Latency from last accept to o_sum_valid is 1 cycle.
- An i_flush with cnt==0 and no accept is ignored and produces no empty sums.
- Output buffer FSM:
  - BUF_EMPTY -> BUF_FULL on close.
  - BUF_FULL -> BUF_EMPTY on i_sum_ready with no close.
  - BUF_FULL stays BUF_FULL on i_sum_ready with a simultaneous close: the old sum drains and the new sum loads in the same cycle.
- o_sum and o_sum_cnt hold stable while o_sum_valid && !i_sum_ready.
- o_prod_ready is combinational: it drops to 0 only when the buffer is full, i_sum_ready is 0, and the cycle would close a vector (cnt==VEC_LEN-1, or i_flush with cnt>0).
- When the previous condition blocks a flush with cnt>0, the flush has no effect. The requester must hold i_flush until it takes effect.
- Non-closing accepts proceed while the buffer is full.
- Arithmetic: two's-complement throughout; i_prod is sign-extended to ACC_W. No overflow is possible given the ACC_W constraint.

Optional Feature:
- Macro MAC_SAT_EN.
- Defined: at buffer load, the sum is clipped to the signed PROD_W range [-2^(PROD_W-1), 2^(PROD_W-1)-1] and sign-extended into o_sum. o_sat=1 when clipping occurred, held with the sum.
- Undefined: full ACC_W sum passed through; o_sat tied 0; no clip logic synthesised.

Decomposition:
- Package mac_pkg holds:
  - constants PROD_W_DEF, ACC_W_DEF, VEC_LEN_DEF.
  - typedef enum logic {BUF_EMPTY, BUF_FULL} buf_state_e.
  - function sat_clip(acc) -> {sat flag, clipped value}.
- One sub-module, sum_out_buf: the one-entry valid/ready holding register for sum, count and sat.
- Accumulator and counter stay in the top module.

Test Plan:
- VEC_LEN=4; products 100, -50, 7, 3 streamed with i_sum_ready=1 -> one cycle after 4th accept: o_sum=60, o_sum_cnt=4, o_sum_valid pulses 1 cycle.
- Products 10, 20, then i_flush with third product 5 -> o_sum=35, o_sum_cnt=3. Then i_flush alone with cnt==0 -> no o_sum_valid.
- i_sum_ready=0 with first sum buffered; stream next vector -> first 3 accepted, o_prod_ready=0 while 4th is offered. Raise i_sum_ready -> first sum drains and second sum loads in the same cycle.
- 4 x 0x7FFFFFFF without MAC_SAT_EN -> o_sum=0x01FFFFFFFC, o_sat=0. With MAC_SAT_EN -> o_sum=0x007FFFFFFF, o_sat=1. 4 x 0x80000000 with MAC_SAT_EN -> o_sum=0xFF80000000, o_sat=1.
- Assert i_rst_n=0 for one cycle after 2 accepts with a sum buffered -> all outputs 0. A following 4-product vector sums only post-reset products.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared definitions for the product accumulator stage: default widths,
// output buffer state encoding and the optional saturation helper.
package mac_pkg;

    localparam int unsigned PROD_W_DEF  = 32;
    localparam int unsigned ACC_W_DEF   = 40;
    localparam int unsigned VEC_LEN_DEF = 8;

    // Working width of the clip helper; covers any legal ACC_W up to 64.
    localparam int unsigned SAT_W = 64;

    typedef enum logic {BUF_EMPTY, BUF_FULL} buf_state_e;

    typedef struct packed {
        logic             sat;
        logic [SAT_W-1:0] val;
    } sat_res_t;

    // Clip a sign-extended sum to the signed prod_w range; flag when clipped.
    function automatic sat_res_t sat_clip(input logic signed [SAT_W-1:0] acc,
                                          input int unsigned            prod_w);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        sat_res_t                res;
        hi = (SAT_W'(1) << (prod_w - 1)) - SAT_W'(1);
        lo = ~hi;
        res.sat = 1'b0;
        res.val = acc;
        if (acc > hi) begin
            res.sat = 1'b1;
            res.val = hi;
        end else if (acc < lo) begin
            res.sat = 1'b1;
            res.val = lo;
        end
        return res;
    endfunction

endpackage

// File: rtl/prod_accum_stage_sum_out_buf.sv
// One-entry valid/ready holding register for a finished sum, its product
// count and its saturation flag.
module sum_out_buf
    import mac_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [ACC_W-1:0] load_sum,
    input  logic [8:0]       load_cnt,
    input  logic             load_sat,
    input  logic             take,
    output logic             valid,
    output logic [ACC_W-1:0] sum,
    output logic [8:0]       cnt,
    output logic             sat
);

    buf_state_e state;
    buf_state_e state_d;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= BUF_EMPTY;
        else        state <= state_d;
    end

    // Next state: a load always leaves the buffer full, even when the old
    // entry drains in the same cycle.
    always_comb begin
        state_d = state;
        case (state)
            BUF_EMPTY: if (load)          state_d = BUF_FULL;
            BUF_FULL:  if (take && !load) state_d = BUF_EMPTY;
            default:                      state_d = BUF_EMPTY;
        endcase
    end

    // Payload registers hold their value until the next load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum <= '0;
            cnt <= '0;
            sat <= 1'b0;
        end else if (load) begin
            sum <= load_sum;
            cnt <= load_cnt;
            sat <= load_sat;
        end
    end

    assign valid = (state == BUF_FULL);

endmodule

// File: rtl/prod_accum_stage.sv
// Accumulates VEC_LEN signed products (or fewer on flush) into a wide sum
// and hands it to a one-entry output buffer. Define MAC_SAT_EN to clip
// each sum to the signed PROD_W range and report clipping on o_sat.
module prod_accum_stage
    import mac_pkg::*;
#(
    parameter int unsigned PROD_W  = PROD_W_DEF,
    parameter int unsigned VEC_LEN = VEC_LEN_DEF,
    parameter int unsigned ACC_W   = ACC_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_prod_valid,
    output logic              o_prod_ready,
    input  logic [PROD_W-1:0] i_prod,
    input  logic              i_flush,
    output logic              o_sum_valid,
    input  logic              i_sum_ready,
    output logic [ACC_W-1:0]  o_sum,
    output logic [8:0]        o_sum_cnt,
    output logic              o_sat
);

    if (VEC_LEN < 1 || VEC_LEN > 256) begin : g_vec_len_chk
        $error("VEC_LEN must be in 1..256");
    end
    if (ACC_W < PROD_W + $clog2(VEC_LEN)) begin : g_acc_w_chk
        $error("ACC_W must be at least PROD_W + clog2(VEC_LEN)");
    end

    logic signed [PROD_W-1:0] prod_s;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  close_sum;
    logic [8:0]               cnt;
    logic [8:0]               close_cnt;
    logic                     last;
    logic                     blocked;
    logic                     accept;
    logic                     close;
    logic                     buf_full;
    logic [ACC_W-1:0]         load_sum;
    logic                     load_sat;

    assign prod_s   = i_prod;
    assign prod_ext = ACC_W'(prod_s);

    // Stall only when a closing cycle would find the buffer full and not draining.
    // The flush term is folded into close so a stalled flush is ignored too.
    assign last         = (cnt == 9'(VEC_LEN - 1));
    assign blocked      = buf_full && !i_sum_ready && (last || (i_flush && cnt != '0));
    assign o_prod_ready = !blocked;
    assign accept       = i_prod_valid && o_prod_ready;
    assign close        = !blocked && ((accept && last) || (i_flush && (cnt != '0 || accept)));
    assign close_sum    = acc + (accept ? prod_ext : '0);
    assign close_cnt    = cnt + 9'(accept);

`ifdef MAC_SAT_EN
    if (ACC_W > SAT_W) begin : g_sat_w_chk
        $error("ACC_W exceeds the clip helper width");
    end

    sat_res_t clip;

    // Clip the closing sum before it enters the buffer.
    always_comb begin
        clip     = sat_clip(SAT_W'(close_sum), PROD_W);
        load_sum = clip.val[ACC_W-1:0];
        load_sat = clip.sat;
    end
`else
    assign load_sum = close_sum;
    assign load_sat = 1'b0;
`endif

    // Running accumulation; a close restarts the next vector from zero.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            acc <= '0;
            cnt <= '0;
        end else if (close) begin
            acc <= '0;
            cnt <= '0;
        end else if (accept) begin
            acc <= acc + prod_ext;
            cnt <= cnt + 9'd1;
        end
    end

    sum_out_buf #(
        .ACC_W(ACC_W)
    ) u_buf (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .load     (close),
        .load_sum (load_sum),
        .load_cnt (close_cnt),
        .load_sat (load_sat),
        .take     (i_sum_ready),
        .valid    (buf_full),
        .sum      (o_sum),
        .cnt      (o_sum_cnt),
        .sat      (o_sat)
    );

    assign o_sum_valid = buf_full;

endmodule
